// File: rtl/cc_regaddr_sel.sv
// Registered register-file address selector: each channel picks IR, MIR, sweep counter or hold.
// A small IDLE/SWEEP FSM walks the sweep counter from First to Last for block save/restore.
module cc_regaddr_sel #(
   parameter int unsigned DATAWIDTH_SCRATCHPAD_DIRECTION = 5,
   parameter int unsigned DATAWIDTH_MIR_DIRECTION        = 6,
   parameter int unsigned NUM_CHANNELS                   = 3
) (
   input  logic                                              CC_REGADDR_SEL_CLOCK_50,
   input  logic                                              CC_REGADDR_SEL_ResetInLow_In,
   input  logic [2*NUM_CHANNELS-1:0]                         CC_REGADDR_SEL_Select_InBus,
   input  logic [NUM_CHANNELS*DATAWIDTH_MIR_DIRECTION-1:0]   CC_REGADDR_SEL_MIRSelection_InBus,
   input  logic [NUM_CHANNELS*DATAWIDTH_SCRATCHPAD_DIRECTION-1:0]
                                                             CC_REGADDR_SEL_ScratchpadSelection_InBus,
   input  logic                                              CC_REGADDR_SEL_Load_In,
   input  logic                                              CC_REGADDR_SEL_SweepStart_In,
   input  logic [DATAWIDTH_MIR_DIRECTION-1:0]                CC_REGADDR_SEL_SweepFirst_InBus,
   input  logic [DATAWIDTH_MIR_DIRECTION-1:0]                CC_REGADDR_SEL_SweepLast_InBus,
   output logic [NUM_CHANNELS*DATAWIDTH_MIR_DIRECTION-1:0]   CC_REGADDR_SEL_data_OutBus,
   output logic                                              CC_REGADDR_SEL_SweepBusy_Out,
   output logic                                              CC_REGADDR_SEL_SweepDone_Out
);

   localparam int unsigned MW = DATAWIDTH_MIR_DIRECTION;
   localparam int unsigned SW = DATAWIDTH_SCRATCHPAD_DIRECTION;
   localparam int unsigned NC = NUM_CHANNELS;

   typedef enum logic [0:0] {StIdle, StSweep} state_e;

   state_e              state_q;
   logic [MW-1:0]       cnt_q;
   logic [MW-1:0]       last_q;
   logic                busy_q;
   logic                done_q;
   logic [NC*MW-1:0]    data_q;
   logic [NC*MW-1:0]    data_d;

   // Source 10 always sees the pre-edge counter, so a Start+Load edge captures the old value.
   always_comb begin
      data_d = data_q;
      if (CC_REGADDR_SEL_Load_In) begin
         for (int c = 0; c < int'(NC); c++) begin
            unique case (CC_REGADDR_SEL_Select_InBus[2*c +: 2])
               2'b00: data_d[c*MW +: MW] =
                         {{(MW-SW){1'b0}}, CC_REGADDR_SEL_ScratchpadSelection_InBus[c*SW +: SW]};
               2'b01: data_d[c*MW +: MW] = CC_REGADDR_SEL_MIRSelection_InBus[c*MW +: MW];
               2'b10: data_d[c*MW +: MW] = cnt_q;
               2'b11: data_d[c*MW +: MW] = data_q[c*MW +: MW];
            endcase
         end
      end
   end

   always_ff @(posedge CC_REGADDR_SEL_CLOCK_50 or negedge CC_REGADDR_SEL_ResetInLow_In) begin
      if (!CC_REGADDR_SEL_ResetInLow_In) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   always_ff @(posedge CC_REGADDR_SEL_CLOCK_50 or negedge CC_REGADDR_SEL_ResetInLow_In) begin
      if (!CC_REGADDR_SEL_ResetInLow_In) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         last_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (CC_REGADDR_SEL_SweepStart_In) begin
                  state_q <= StSweep;
                  cnt_q   <= CC_REGADDR_SEL_SweepFirst_InBus;
                  last_q  <= CC_REGADDR_SEL_SweepLast_InBus;
                  busy_q  <= 1'b1;
               end
            end
            StSweep: begin
               // Counter parks on Last when the sweep ends; wraps naturally otherwise.
               if (CC_REGADDR_SEL_Load_In) begin
                  if (cnt_q == last_q) begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + MW'(1);
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign CC_REGADDR_SEL_data_OutBus   = data_q;
   assign CC_REGADDR_SEL_SweepBusy_Out = busy_q;
   assign CC_REGADDR_SEL_SweepDone_Out = done_q;

endmodule

// File: tb/tb_cc_regaddr_sel.sv
// Bench for cc_regaddr_sel: directed vector table, reset/sweep sequences, then random
// stimulus checked against a queue-based model of the sweep.
module tb_cc_regaddr_sel;

   localparam int MW = 6;
   localparam int SW = 5;
   localparam int NC = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [2*NC-1:0]   sel;
   logic [NC*MW-1:0]  mir;
   logic [NC*SW-1:0]  ir;
   logic              load;
   logic              start;
   logic [MW-1:0]     first;
   logic [MW-1:0]     last;
   logic [NC*MW-1:0]  data;
   logic              busy;
   logic              done;

   int tests = 0;
   int fails = 0;

   cc_regaddr_sel dut (
      .CC_REGADDR_SEL_CLOCK_50                  (clk),
      .CC_REGADDR_SEL_ResetInLow_In             (rst_n),
      .CC_REGADDR_SEL_Select_InBus              (sel),
      .CC_REGADDR_SEL_MIRSelection_InBus        (mir),
      .CC_REGADDR_SEL_ScratchpadSelection_InBus (ir),
      .CC_REGADDR_SEL_Load_In                   (load),
      .CC_REGADDR_SEL_SweepStart_In             (start),
      .CC_REGADDR_SEL_SweepFirst_InBus          (first),
      .CC_REGADDR_SEL_SweepLast_InBus           (last),
      .CC_REGADDR_SEL_data_OutBus               (data),
      .CC_REGADDR_SEL_SweepBusy_Out             (busy),
      .CC_REGADDR_SEL_SweepDone_Out             (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2*NC-1:0]  sel;
      logic [NC*MW-1:0] mir;
      logic [NC*SW-1:0] ir;
      logic             load;
      logic             start;
      logic [MW-1:0]    first;
      logic [MW-1:0]    last;
      logic [NC*MW-1:0] exp_data;
      logic             exp_busy;
      logic             exp_done;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [NC*MW-1:0] rep(input logic [MW-1:0] v);
      return {v, v, v};
   endfunction

   task automatic add(input logic [2*NC-1:0] s, input logic [NC*MW-1:0] m,
                      input logic [NC*SW-1:0] i, input logic ld, input logic st,
                      input logic [MW-1:0] f, input logic [MW-1:0] l,
                      input logic [NC*MW-1:0] ed, input logic eb, input logic edn);
      vec_t v;
      v.sel = s; v.mir = m; v.ir = i; v.load = ld; v.start = st; v.first = f; v.last = l;
      v.exp_data = ed; v.exp_busy = eb; v.exp_done = edn;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic [2*NC-1:0] s, input logic ld, input logic st,
                        input logic [MW-1:0] f, input logic [MW-1:0] l);
      sel = s; load = ld; start = st; first = f; last = l;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a sweep is a queue of addresses still to be issued.
   bit               m_busy;
   int               m_q[$];
   int               m_held;
   logic [NC*MW-1:0] m_data;
   bit               m_done;

   task automatic model_reset();
      m_busy = 0; m_q.delete(); m_held = 0; m_data = '0; m_done = 0;
   endtask

   task automatic model_step();
      int cur;
      int a;
      int p;
      logic [NC*MW-1:0] nd;
      cur = m_busy ? m_q[0] : m_held;
      nd = m_data;
      if (load) begin
         for (int c = 0; c < NC; c++) begin
            case (sel[2*c +: 2])
               2'd0: nd[c*MW +: MW] = MW'(ir[c*SW +: SW]);
               2'd1: nd[c*MW +: MW] = mir[c*MW +: MW];
               2'd2: nd[c*MW +: MW] = MW'(cur);
               default: ;
            endcase
         end
      end
      m_done = 0;
      if (!m_busy && start) begin
         m_q.delete();
         a = int'(first);
         for (int k = 0; k < 64; k++) begin
            m_q.push_back(a);
            if (a == int'(last)) break;
            a = (a + 1) % 64;
         end
         m_busy = 1;
      end else if (m_busy && load) begin
         p = m_q.pop_front();
         if (m_q.size() == 0) begin
            m_busy = 0;
            m_held = p;
            m_done = 1;
         end
      end
      m_data = nd;
   endtask

   initial begin
      logic [MW-1:0] rf;

      rst_n = 1'b0;
      drive(6'b0, 1'b0, 1'b0, 6'd0, 6'd0);
      mir = '0; ir = '0;
      #12;
      check("reset data", 32'(data), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // IR / MIR capture and Load=0 hold
      add(6'b000000, '0, {5'd3, 5'd17, 5'd31}, 1, 0, 0, 0, {6'd3, 6'd17, 6'd31}, 0, 0);
      add(6'b010101, {6'd40, 6'd63, 6'd0}, '0, 1, 0, 0, 0, {6'd40, 6'd63, 6'd0}, 0, 0);
      add(6'b010101, {6'd1, 6'd2, 6'd3}, '0, 0, 0, 0, 0, {6'd40, 6'd63, 6'd0}, 0, 0);
      add(6'b010101, {6'd5, 6'd6, 6'd7}, '0, 0, 0, 0, 0, {6'd40, 6'd63, 6'd0}, 0, 0);
      // Sweep 8..11 on channel 2
      add(6'b101111, '0, '0, 0, 1, 8, 11, {6'd40, 6'd63, 6'd0}, 1, 0);
      add(6'b101111, '0, '0, 1, 0, 0, 0, {6'd8, 6'd63, 6'd0}, 1, 0);
      add(6'b101111, '0, '0, 1, 0, 0, 0, {6'd9, 6'd63, 6'd0}, 1, 0);
      add(6'b101111, '0, '0, 1, 0, 0, 0, {6'd10, 6'd63, 6'd0}, 1, 0);
      add(6'b101111, '0, '0, 1, 0, 0, 0, {6'd11, 6'd63, 6'd0}, 0, 1);
      add(6'b101111, '0, '0, 0, 0, 0, 0, {6'd11, 6'd63, 6'd0}, 0, 0);
      // Counter held at Last in IDLE
      add(6'b111011, '0, '0, 1, 0, 0, 0, {6'd11, 6'd11, 6'd0}, 0, 0);
      // Wrap sweep 62..1, Start+Load together, mid-sweep Start ignored, gapped Load
      add(6'b101010, '0, '0, 1, 1, 62, 1, rep(6'd11), 1, 0);
      add(6'b101010, '0, '0, 1, 0, 0, 0, rep(6'd62), 1, 0);
      add(6'b101010, '0, '0, 1, 1, 5, 5, rep(6'd63), 1, 0);
      add(6'b101010, '0, '0, 0, 0, 0, 0, rep(6'd63), 1, 0);
      add(6'b101010, '0, '0, 0, 0, 0, 0, rep(6'd63), 1, 0);
      add(6'b101010, '0, '0, 1, 0, 0, 0, rep(6'd0), 1, 0);
      add(6'b101010, '0, '0, 1, 0, 0, 0, rep(6'd1), 0, 1);
      add(6'b101010, '0, '0, 0, 0, 0, 0, rep(6'd1), 0, 0);
      // First == Last
      add(6'b101010, '0, '0, 0, 1, 20, 20, rep(6'd1), 1, 0);
      add(6'b101010, '0, '0, 1, 0, 0, 0, rep(6'd20), 0, 1);
      add(6'b101010, '0, '0, 1, 0, 0, 0, rep(6'd20), 0, 0);

      foreach (vecs[i]) begin
         sel = vecs[i].sel; mir = vecs[i].mir; ir = vecs[i].ir; load = vecs[i].load;
         start = vecs[i].start; first = vecs[i].first; last = vecs[i].last;
         step();
         check($sformatf("vec%0d data", i), 32'(data), 32'(vecs[i].exp_data));
         check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
         check($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].exp_done));
      end

      // Reset mid-sweep: no Done pulse, fresh sweep afterwards
      drive(6'b101010, 1'b0, 1'b1, 6'd30, 6'd40);
      step();
      check("midrst start busy", 32'(busy), 32'd1);
      drive(6'b101010, 1'b1, 1'b0, 6'd0, 6'd0);
      step();
      check("midrst cap0", 32'(data), 32'(rep(6'd30)));
      step();
      check("midrst cap1", 32'(data), 32'(rep(6'd31)));
      rst_n = 1'b0;
      #1;
      check("midrst data", 32'(data), 32'd0);
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst done", 32'(done), 32'd0);
      drive(6'b101010, 1'b0, 1'b0, 6'd0, 6'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("postrst done", 32'(done), 32'd0);
      check("postrst busy", 32'(busy), 32'd0);
      drive(6'b101010, 1'b1, 1'b0, 6'd0, 6'd0);
      step();
      check("postrst counter", 32'(data), 32'd0);
      drive(6'b101010, 1'b0, 1'b1, 6'd2, 6'd3);
      step();
      drive(6'b101010, 1'b1, 1'b0, 6'd0, 6'd0);
      step();
      check("resweep cap0", 32'(data), 32'(rep(6'd2)));
      check("resweep busy", 32'(busy), 32'd1);
      step();
      check("resweep cap1", 32'(data), 32'(rep(6'd3)));
      check("resweep done", 32'(done), 32'd1);

      // Randomized run against the model
      rst_n = 1'b0;
      #2;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 2000; n++) begin
         sel   = 6'($urandom);
         mir   = 18'($urandom);
         ir    = 15'($urandom);
         load  = ($urandom_range(0, 3) != 0);
         start = ($urandom_range(0, 7) == 0);
         rf    = 6'($urandom);
         first = rf;
         last  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : rf + 6'($urandom_range(0, 5));
         model_step();
         step();
         check($sformatf("rnd%0d data", n), 32'(data), 32'(m_data));
         check($sformatf("rnd%0d busy", n), 32'(busy), 32'(m_busy));
         check($sformatf("rnd%0d done", n), 32'(done), 32'(m_done));
         if ($urandom_range(0, 99) == 0) begin
            rst_n = 1'b0;
            #2;
            model_reset();
            check($sformatf("rnd%0d rst data", n), 32'(data), 32'd0);
            check($sformatf("rnd%0d rst busy", n), 32'(busy), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
